// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests and
// buffers returned words for IF/ID. Optional stall counter under FETCH_STALL_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        if_branch,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic [31:0] pc_from_IF,
  output logic [31:0] inst_from_IF,
  output logic        inst_valid
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 2;
  localparam logic [XLEN-1:0] NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [XLEN-1:0] r_fpc;
  logic [CW-1:0]   r_out_cnt;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   r_fifo_cnt;
  logic [XLEN-1:0] r_pcq       [2];
  logic [XLEN-1:0] r_fifo_pc   [2];
  logic [XLEN-1:0] r_fifo_inst [2];

  logic            w_valid;
  logic            w_pop;
  logic [2:0]      w_credit;
  logic            w_issue;
  logic            w_resp;
  logic            w_keep;
  logic            w_pcq_idx;
  logic            w_fifo_idx;

  assign w_valid  = (r_fifo_cnt != '0);
  assign w_pop    = w_valid && !stall;
  // Slots already committed: in flight plus buffered, less the head leaving now.
  assign w_credit = 3'(r_out_cnt) + 3'(r_fifo_cnt) - 3'(w_pop);
  assign imem_req = !reset && !if_branch && (w_credit < 3'd2);
  assign w_issue  = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp   = imem_rvalid && (r_out_cnt != '0);
  assign w_keep   = w_resp && (r_drop_cnt == '0) && !if_branch;

  // Credit limits both queues to two entries, so a 1-bit write index suffices.
  assign w_pcq_idx  = 1'(r_out_cnt - CW'(w_resp));
  assign w_fifo_idx = 1'(r_fifo_cnt - CW'(w_pop));

  assign imem_addr    = r_fpc;
  assign inst_valid   = w_valid;
  assign pc_from_IF   = w_valid ? r_fifo_pc[0]   : '0;
  assign inst_from_IF = w_valid ? r_fifo_inst[0] : NOP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fpc      <= RESET_PC & ALIGN_MASK;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
      r_fifo_cnt <= '0;
      for (int i = 0; i < 2; i++) begin
        r_pcq[i]       <= '0;
        r_fifo_pc[i]   <= '0;
        r_fifo_inst[i] <= '0;
      end
    end else begin
      if (w_resp) r_pcq[0] <= r_pcq[1];
      if (w_issue) r_pcq[w_pcq_idx] <= r_fpc;
      r_out_cnt <= r_out_cnt + CW'(w_issue) - CW'(w_resp);

      if (if_branch) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fpc      <= branch_target & ALIGN_MASK;
        r_fifo_cnt <= '0;
        r_drop_cnt <= r_out_cnt - CW'(w_resp);
      end else begin
        if (w_issue) r_fpc <= r_fpc + 32'd4;
        if (w_resp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (w_pop) begin
          r_fifo_pc[0]   <= r_fifo_pc[1];
          r_fifo_inst[0] <= r_fifo_inst[1];
        end
        if (w_keep) begin
          r_fifo_pc[w_fifo_idx]   <= r_pcq[0];
          r_fifo_inst[w_fifo_idx] <= imem_rdata;
        end
        r_fifo_cnt <= r_fifo_cnt + CW'(w_keep) - CW'(w_pop);
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [XLEN-1:0] r_stall_cnt;

  // Counts cycles where a valid head is held back by downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stall_cnt <= '0;
    else if (w_valid && stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a behavioural memory and
// expected-stream model drive stimulus; a negedge monitor checks delivered words.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_branch;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] pc_from_IF;
  logic [31:0] inst_from_IF;
  logic        inst_valid;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_branch    (if_branch),
    .branch_target(branch_target),
    .stall        (stall),
    .pc_from_IF   (pc_from_IF),
    .inst_from_IF (inst_from_IF),
    .inst_valid   (inst_valid)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  mem_t        mem_q[$];
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          buf_cnt = 0;
  int          last_due = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [31:0] exp_fetch = RST_PC;
  logic [31:0] exp_sc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_reset();
    mem_q.delete();
    sb.delete();
    buf_cnt   = 0;
    last_due  = 0;
    epoch++;
    exp_fetch = RST_PC;
    exp_sc    = 0;
  endtask

  // One clock of stimulus plus the reference model's view of that cycle.
  task automatic step(input logic br, input logic [31:0] tgt, input logic st, input logic gn);
    bit   exp_valid;
    bit   pop;
    bit   exp_req;
    int   d;
    mem_t m;
    @(posedge clk);
    #1;
    cyc++;
    if_branch     = br;
    branch_target = tgt;
    stall         = st;
    imem_gnt      = gn;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    exp_valid = (buf_cnt > 0);
    pop       = exp_valid && !st;
    exp_req   = !br && ((mem_q.size() + buf_cnt - (pop ? 1 : 0)) < 2);
    chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
    chk("imem_req", 32'(imem_req), 32'(exp_req));
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, exp_sc);
    if (exp_valid && st) exp_sc++;
`endif
    if (imem_req && gn) begin
      chk("imem_addr", imem_addr, exp_fetch);
      d = cyc + $urandom_range(lat_lo, lat_hi);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      m.addr = imem_addr; m.due = d; m.epoch = epoch;
      mem_q.push_back(m);
      sb.push_back('{pc: exp_fetch, inst: mem_word(exp_fetch)});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (imem_rvalid) begin
      m = mem_q.pop_front();
      if (m.epoch == epoch && !br) buf_cnt++;
    end
    if (pop && !br) buf_cnt--;
    if (br) begin
      epoch++;
      buf_cnt = 0;
      sb.delete();
      exp_fetch = tgt & 32'hFFFF_FFFC;
    end
  endtask

  // Monitor: the head must match the oldest expected word; it leaves on pop.
  always @(negedge clk) begin
    if (!reset && inst_valid && !if_branch) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underflow: got pc %h with no expected word (cycle %0d)", pc_from_IF, cyc);
      end else begin
        chk("head_pc", pc_from_IF, sb[0].pc);
        chk("head_inst", inst_from_IF, sb[0].inst);
        if (!stall) void'(sb.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    if_branch = 1'b0; branch_target = '0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", pc_from_IF, 32'd0);
    chk("rst_inst", inst_from_IF, NOP);
    chk("rst_req", 32'(imem_req), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Fill and streaming with a 1-cycle memory.
    repeat (20) step(1'b0, '0, 1'b0, 1'b1);
    // Stall with a full buffer, then release.
    repeat (3) step(1'b0, '0, 1'b1, 1'b1);
    repeat (8) step(1'b0, '0, 1'b0, 1'b1);
    // Redirect with two slow requests in flight.
    lat_lo = 3; lat_hi = 3;
    repeat (6) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h0000_2003, 1'b0, 1'b1);
    repeat (12) step(1'b0, '0, 1'b0, 1'b1);
    // Redirect coinciding with a response while stalled.
    lat_lo = 1; lat_hi = 1;
    repeat (5) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h0000_3000, 1'b1, 1'b1);
    repeat (6) step(1'b0, '0, 1'b0, 1'b1);
    // Address wrap past 32'hFFFF_FFFC.
    step(1'b1, 32'hFFFF_FFF4, 1'b0, 1'b1);
    repeat (10) step(1'b0, '0, 1'b0, 1'b1);
    // Five cycles of held valid head.
    repeat (5) step(1'b0, '0, 1'b1, 1'b1);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic.
    lat_lo = 1; lat_hi = 4;
    repeat (600) begin
      logic br;
      br = ($urandom_range(0, 99) < 4);
      step(br, $urandom, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 70));
    end

    // Asynchronous reset mid-cycle with requests in flight.
    lat_lo = 3; lat_hi = 3;
    repeat (6) step(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("mid_rst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_pc", pc_from_IF, 32'd0);
    chk("mid_rst_inst", inst_from_IF, NOP);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, RST_PC);
    model_reset();
`ifdef FETCH_STALL_CNT_EN
    chk("mid_rst_stall_cnt", stall_cnt, 32'd0);
`endif
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    lat_lo = 1; lat_hi = 2;
    repeat (20) step(1'b0, '0, 1'b0, 1'b1);

    // Drain: stop fetching and let every expected word come out.
    guard = 0;
    while ((sb.size() > 0 || mem_q.size() > 0) && guard < 50) begin
      step(1'b0, '0, 1'b0, 1'b0);
      guard++;
    end
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("drain_mem", 32'(mem_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the IF/ID pipeline register. It owns the fetch PC and issues in-order requests to instruction memory over a request/grant/response handshake with variable latency. Returned words go into a 2-entry instruction buffer, which feeds `pc_from_IF`/`inst_from_IF` to IF/ID. A taken branch from decode redirects the PC, flushes the buffer and discards in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk`  input  1  sole clock; all state updates on posedge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `imem_req`  output  1  fetch request valid.
- `imem_addr`  output  32  word-aligned fetch address; bits [1:0] always 0.
- `imem_gnt`  input  1  memory accepts request this cycle (req&&gnt = issue).
- `imem_rvalid`  input  1  response valid; responses in issue order, never back-pressured.
- `imem_rdata`  input  32  response instruction word.
- `if_branch`  input  1  single-cycle redirect from decode.
- `branch_target`  input  32  redirect address; bits [1:0] ignored (forced 00).
- `stall`  input  1  downstream not accepting this cycle.
- `pc_from_IF`  output  32  PC of buffer head.
- `inst_from_IF`  output  32  instruction at buffer head.
- `inst_valid`  output  1  buffer head valid.

## Operation
- State: `fpc` (next fetch address), `outstanding` (0..2), `drop_cnt` (0..2, ≤ outstanding), 2-entry FIFO of {pc, inst}, 2-entry pc queue recording the address of each issued request.
- Reset values: `fpc`=RESET_PC, FIFO and pc queue empty, `outstanding`=0, `drop_cnt`=0. Outputs: `imem_req`=0, `inst_valid`=0, `pc_from_IF`=0, `inst_from_IF`=32'h0000_0013 (NOP).
- Pop: `pop` = `inst_valid && !stall`.
- Credit: `imem_req` = `!if_branch && (outstanding + fifo_count - pop) < 2`.
- `imem_addr` = `fpc`.
- Issue (req&&gnt): `fpc` += 4 (32-bit wrap from 32'hFFFF_FFFC to 0), push `fpc` onto the pc queue, `outstanding`++.
- Response (rvalid):
  - Always: `outstanding`-- and pop the pc queue.
  - If `drop_cnt`>0: discard the response and decrement `drop_cnt`.
  - Otherwise: push {queued pc, `imem_rdata`} into the FIFO.
- The credit rule guarantees FIFO space for every response. `imem_rvalid` with `outstanding`==0 is a protocol error and is ignored.
- Output: when the FIFO is non-empty, the head is driven. When empty, `inst_valid`=0, `pc_from_IF`=0, `inst_from_IF`=NOP.
- Redirect (`if_branch`=1):
  - `fpc` <= {`branch_target`[31:2],2'b00}.
  - FIFO flushed.
  - `drop_cnt` <= `outstanding` − `imem_rvalid`; the pc queue keeps entries only for requests still to be dropped.
  - No request is issued that cycle.
- Simultaneous events:
  - Branch with stall or pop: branch wins, and the buffer is flushed regardless.
  - Branch with rvalid: that response is dropped.
  - Issue with response in the same cycle: `outstanding` is unchanged.
- Reset mid-operation: all in-flight requests are forgotten. The memory model must also be reset.

## Timing
- Issue at cycle T with a response at T+k (k≥1) gives `inst_valid` at T+k+1.
- With k=1 and `stall`=0, sustained throughput is 1 instruction/cycle after a 2-cycle fill.
- After a redirect at cycle B:
  - The first target request is issued at B+1.
  - The earliest valid target instruction appears at B+3 (k=1), after any drops complete.
- `stall` holds the head outputs stable. No pop occurs while `stall` is high, and fetch stops once the credit is exhausted.
- `imem_req` is combinational from state, `stall` and `if_branch`. All other outputs come from registers or the FIFO head.

## Configuration
- `FETCH_STALL_CNT_EN`: when defined, adds port `stall_cnt`, output, 32 bits.
  - It increments each cycle `inst_valid && stall`, wraps at 2^32, and resets to 0.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Reset release, RESET_PC=32'h100, 1-cycle memory, no stall -> addresses 0x100, 0x104, 0x108… issued on consecutive cycles; `pc_from_IF`=0x100 with `inst_valid` at cycle 2; one instruction/cycle thereafter.
- `stall` high 3 cycles with buffer full -> `imem_req`=0 once credit hits 2; head pc/inst unchanged; no words lost or duplicated after release.
- Memory latency 3 cycles with 2 requests outstanding, `if_branch` with target 0x2003 -> both old responses dropped; next `imem_addr`=0x2000; `pc_from_IF`=0x2000 is the first valid output.
- `if_branch` in the same cycle as `imem_rvalid` with `stall`=1 -> response discarded, FIFO empty, `imem_req`=0 that cycle and 1 the next.
- `fpc`=32'hFFFF_FFFC -> next address 0x0000_0000.
- Asynchronous `reset` pulse mid-cycle with 2 outstanding -> outputs immediately return to reset values.
- With `FETCH_STALL_CNT_EN` defined, 5 cycles of `inst_valid && stall` -> `stall_cnt`=5.
